matrix_frame_ring: RTL and testbench
====================================

// Module: matrix_frame_ring
// PURPOSE
//  N-deep frame ring for the LED-matrix path, generalising the two-buffer swap scheme.
//  Holds BUFFER_COUNT frames of CHANNEL_COUNT parallel blocks, each with per-frame width/height metadata.
//  The writer commits whole frames; the reader acquires them. Two modes: FIFO (in order, writer stalls) or
//  LATEST (newest frame wins, older pending frames dropped). Sits between the HDMI frame writer and matrix output.
// PARAMETERS
//  CHANNEL_COUNT   12    parallel blocks (banks*blocks) per frame
//  BYTES_PER_BLOCK 2250  storage per channel per frame
//  BUFFER_COUNT    3     frames in ring; FIFO mode >=2, LATEST mode >=3
//  DATA_WIDTH_A    32    write word width per channel
//  DATA_WIDTH_B    8     read word width per channel; A/B is a power of two >=1
//  MAX_WIDTH       1920  metadata width range
//  MAX_HEIGHT      1080  metadata height range
//  LATEST_MODE     0     0=FIFO, 1=LATEST
//  derived: AW_A=$clog2(BYTES_PER_BLOCK*8/DATA_WIDTH_A), AW_B=$clog2(BYTES_PER_BLOCK*8/DATA_WIDTH_B)
// PORTS
//  I_clk             in   1                      single clock
//  I_rst_n           in   1                      asynchronous, active-low reset
//  I_write_enable    in   1                      write I_data_flat to current write frame
//  I_write_address   in   AW_A                   word address, common to all channels
//  I_data_flat       in   CHANNEL_COUNT*A        channel c at [c*A +: A]
//  I_image_width     in   $clog2(MAX_WIDTH)      metadata, sampled on I_commit
//  I_image_height    in   $clog2(MAX_HEIGHT)     metadata, sampled on I_commit
//  I_commit          in   1                      pulse: current write frame complete
//  O_write_ready     out  1                      a write frame is owned; writes/commits ignored while 0
//  I_acquire         in   1                      pulse: reader releases its frame, takes next ready frame
//  I_read_enable     in   1                      read request
//  I_read_address    in   AW_B                   sub-word address, common to all channels
//  O_data_flat       out  CHANNEL_COUNT*B        channel c at [c*B +: B]
//  O_data_valid      out  1                      O_data_flat valid this cycle
//  O_frame_available out  1                      >=1 frame READY
//  O_frame_valid     out  1                      reader owns a frame
//  O_image_width     out  $clog2(MAX_WIDTH)      metadata of reader's frame
//  O_image_height    out  $clog2(MAX_HEIGHT)     metadata of reader's frame
//  O_buffer_updated  out  1                      one-cycle pulse after successful acquire
//  O_dropped_count   out  16                     frames discarded in LATEST mode, saturating
// BEHAVIOUR
//  Frame states: FREE, WRITING, READY, READING. Max one WRITING and one READING at any time.
//  Reset: buffer 0 WRITING, rest FREE; O_write_ready=1. All other outputs 0, ready queue empty.
//   Memory is not cleared. Reset mid-frame discards all frames.
//  Write: while O_write_ready and I_write_enable, the word is stored in the WRITING frame, all channels, same cycle.
//  Commit (O_write_ready=1): latch metadata into WRITING frame; frame -> READY, appended to tail of ready queue.
//   LATEST: any older READY frames -> FREE, O_dropped_count += number freed (saturates at 16'hFFFF).
//   Next write frame = lowest-index buffer FREE at the start of the cycle (including one freed by same-cycle acquire);
//   O_write_ready stays 1. If none exists (FIFO only), O_write_ready=0 from the next cycle; the lowest FREE buffer
//   is claimed the cycle after one appears, and O_write_ready=1 the cycle after that.
//  Acquire: if the ready queue is non-empty at the start of the cycle, the READING frame (if any) -> FREE.
//   Queue head -> READING; O_image_* updated; O_frame_valid=1; O_buffer_updated=1 the next cycle.
//   Empty queue: acquire ignored, no pulse, reader keeps its current frame.
//   A frame committed in the same cycle is not visible to that acquire.
//  Simultaneous commit+acquire: both apply; acquire uses the pre-cycle queue; commit appends after the pop.
//  Read: O_data_flat and O_data_valid registered, latency 1.
//   O_data_valid = I_read_enable & O_frame_valid, delayed one cycle. O_data_flat holds when not valid.
//   Sub-word select = low log2(A/B) bits of I_read_address; sub-word 0 = bits [B-1:0] of the A word.
//  O_frame_available = queue non-empty (registered state). Out-of-range addresses: undefined data, no state change.
// TESTING
//  1 FIFO, BC=3: write frames W=16,H=8 ramp (ch c word n=c*256+n), commit, acquire -> O_buffer_updated pulse 1 cycle later;
//    read address 0..3 returns bytes 00,00,00,00 then addr 4 -> 01 (ch0); O_data_valid 1 cycle after enable.
//  2 FIFO, BC=2: commit twice without acquire -> O_write_ready=0 next cycle; writes ignored; acquire -> O_write_ready=1
//    within 2 cycles; frames delivered in commit order (metadata H=1 then H=2).
//  3 LATEST, BC=3: commit frames H=1,2,3 with no acquire -> O_dropped_count=2; acquire -> O_image_height=3.
//  4 Same-cycle commit+acquire with one frame queued -> reader gets older frame; new frame stays READY,
//    O_frame_available=1.
//  5 Acquire on empty queue -> no pulse, O_frame_valid unchanged.
//  6 Reset asserted mid-write and mid-read -> all outputs 0 asynchronously; after release O_write_ready=1, buffer 0 written.

Source files
------------

// File: rtl/matrix_frame_ring.sv
// matrix_frame_ring
// -----------------------------------------------------------------------------
// Ring of BUFFER_COUNT frames between the HDMI frame writer and the LED-matrix
// output. Each frame holds CHANNEL_COUNT parallel blocks plus width/height
// metadata. The writer owns at most one frame (WRITING) and hands it over with
// a commit; committed frames wait in an ordered ready queue (READY) until the
// reader acquires one (READING). FIFO mode delivers every frame in order and
// stalls the writer when no frame is free; LATEST mode keeps only the newest
// committed frame and counts the ones it throws away.
//
// Ports
//   I_clk, I_rst_n        clock, asynchronous active-low reset
//   I_write_enable        store I_data_flat at I_write_address in the write frame
//   I_write_address       word address, shared by all channels
//   I_data_flat           write data, channel c at [c*A +: A]
//   I_image_width/height  metadata captured on I_commit
//   I_commit              pulse: the write frame is complete
//   O_write_ready         a write frame is owned; writes and commits need it
//   I_acquire             pulse: release the reader frame, take the next ready one
//   I_read_enable         read request
//   I_read_address        sub-word address, shared by all channels
//   O_data_flat           read data, channel c at [c*B +: B], latency 1
//   O_data_valid          O_data_flat carries the result of a read this cycle
//   O_frame_available     at least one frame is READY
//   O_frame_valid         the reader owns a frame
//   O_image_width/height  metadata of the reader frame
//   O_buffer_updated      one-cycle pulse after a successful acquire
//   O_dropped_count       frames discarded in LATEST mode, saturating
// -----------------------------------------------------------------------------
module matrix_frame_ring #(
  parameter int CHANNEL_COUNT   = 12,
  parameter int BYTES_PER_BLOCK = 2250,
  parameter int BUFFER_COUNT    = 3,
  parameter int DATA_WIDTH_A    = 32,
  parameter int DATA_WIDTH_B    = 8,
  parameter int MAX_WIDTH       = 1920,
  parameter int MAX_HEIGHT      = 1080,
  parameter int LATEST_MODE     = 0,
  localparam int AW_A = $clog2(BYTES_PER_BLOCK * 8 / DATA_WIDTH_A),
  localparam int AW_B = $clog2(BYTES_PER_BLOCK * 8 / DATA_WIDTH_B),
  localparam int WW   = $clog2(MAX_WIDTH),
  localparam int HW   = $clog2(MAX_HEIGHT)
) (
  input  logic                                  I_clk,
  input  logic                                  I_rst_n,
  input  logic                                  I_write_enable,
  input  logic [AW_A-1:0]                       I_write_address,
  input  logic [CHANNEL_COUNT*DATA_WIDTH_A-1:0] I_data_flat,
  input  logic [WW-1:0]                         I_image_width,
  input  logic [HW-1:0]                         I_image_height,
  input  logic                                  I_commit,
  output logic                                  O_write_ready,
  input  logic                                  I_acquire,
  input  logic                                  I_read_enable,
  input  logic [AW_B-1:0]                       I_read_address,
  output logic [CHANNEL_COUNT*DATA_WIDTH_B-1:0] O_data_flat,
  output logic                                  O_data_valid,
  output logic                                  O_frame_available,
  output logic                                  O_frame_valid,
  output logic [WW-1:0]                         O_image_width,
  output logic [HW-1:0]                         O_image_height,
  output logic                                  O_buffer_updated,
  output logic [15:0]                           O_dropped_count
);

  localparam int DEPTH = BYTES_PER_BLOCK * 8 / DATA_WIDTH_A;
  localparam int RATIO = DATA_WIDTH_A / DATA_WIDTH_B;
  localparam int SUB_W = $clog2(RATIO);
  localparam int BW    = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
  localparam int CW    = $clog2(BUFFER_COUNT + 1);
  localparam int WIDE  = CHANNEL_COUNT * DATA_WIDTH_A;
  localparam int NARROW = CHANNEL_COUNT * DATA_WIDTH_B;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2,
    READING = 2'd3
  } frame_state_t;

  // Ring bookkeeping
  frame_state_t      state_q [BUFFER_COUNT];
  frame_state_t      state_n [BUFFER_COUNT];
  logic [BW-1:0]     queue_q [BUFFER_COUNT];
  logic [BW-1:0]     queue_n [BUFFER_COUNT];
  logic [CW-1:0]     count_q, count_n;
  logic [BW-1:0]     write_buf_q, write_buf_n;
  logic              write_owned_q, write_owned_n;
  logic [BW-1:0]     read_buf_q, read_buf_n;
  logic              read_owned_q, read_owned_n;
  logic [WW-1:0]     image_width_q, image_width_n;
  logic [HW-1:0]     image_height_q, image_height_n;
  logic              updated_q;
  logic [15:0]       dropped_q, dropped_n;

  // Per-frame metadata and storage
  logic [WW-1:0]     meta_width  [BUFFER_COUNT];
  logic [HW-1:0]     meta_height [BUFFER_COUNT];
  logic [WIDE-1:0]   mem [BUFFER_COUNT][DEPTH];

  // Next-state helpers
  logic                    acquire_ok;
  logic                    commit_ok;
  logic [BUFFER_COUNT-1:0] start_free;
  logic [BUFFER_COUNT-1:0] free_mask;
  logic [BUFFER_COUNT-1:0] drop_mask;
  int                      drop_total;
  logic [16:0]             drop_sum;
  logic                    claim;
  logic [BW-1:0]           claim_buf;

  // Read datapath
  logic [AW_A-1:0]   rd_word_addr;
  int                rd_sub;
  logic [WIDE-1:0]   rd_word;
  logic [NARROW-1:0] rd_data;
  logic [NARROW-1:0] data_q;
  logic              valid_q;

  function automatic logic [BW-1:0] lowest_set(input logic [BUFFER_COUNT-1:0] mask);
    lowest_set = '0;
    for (int b = BUFFER_COUNT - 1; b >= 0; b--) begin
      if (mask[b]) lowest_set = BW'(b);
    end
  endfunction

  // State register: frame states, ready queue, ownership and registered outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int b = 0; b < BUFFER_COUNT; b++) begin
        state_q[b] <= (b == 0) ? WRITING : FREE;
        queue_q[b] <= '0;
      end
      count_q        <= '0;
      write_buf_q    <= '0;
      write_owned_q  <= 1'b1;
      read_buf_q     <= '0;
      read_owned_q   <= 1'b0;
      image_width_q  <= '0;
      image_height_q <= '0;
      updated_q      <= 1'b0;
      dropped_q      <= '0;
    end else begin
      state_q        <= state_n;
      queue_q        <= queue_n;
      count_q        <= count_n;
      write_buf_q    <= write_buf_n;
      write_owned_q  <= write_owned_n;
      read_buf_q     <= read_buf_n;
      read_owned_q   <= read_owned_n;
      image_width_q  <= image_width_n;
      image_height_q <= image_height_n;
      updated_q      <= acquire_ok;
      dropped_q      <= dropped_n;
    end
  end

  // Next-state logic. Acquire is evaluated against the queue as it stood at the
  // start of the cycle and pops first; a same-cycle commit then appends behind
  // it, so a frame never reaches the reader in the cycle it is committed.
  // A buffer released by a same-cycle acquire counts as free for the writer.
  always_comb begin
    state_n        = state_q;
    queue_n        = queue_q;
    count_n        = count_q;
    write_buf_n    = write_buf_q;
    write_owned_n  = write_owned_q;
    read_buf_n     = read_buf_q;
    read_owned_n   = read_owned_q;
    image_width_n  = image_width_q;
    image_height_n = image_height_q;
    dropped_n      = dropped_q;
    drop_mask      = '0;
    drop_total     = 0;
    drop_sum       = '0;
    claim          = 1'b0;
    claim_buf      = '0;

    acquire_ok = I_acquire && (count_q != '0);
    commit_ok  = I_commit && write_owned_q;

    for (int b = 0; b < BUFFER_COUNT; b++) begin
      start_free[b] = (state_q[b] == FREE);
      free_mask[b]  = (state_q[b] == FREE) ||
                      (acquire_ok && read_owned_q && (BW'(b) == read_buf_q));
    end

    if (acquire_ok) begin
      for (int b = 0; b < BUFFER_COUNT; b++) begin
        if (read_owned_q && (BW'(b) == read_buf_q)) state_n[b] = FREE;
        if (BW'(b) == queue_q[0]) state_n[b] = READING;
      end
      read_buf_n     = queue_q[0];
      read_owned_n   = 1'b1;
      image_width_n  = meta_width[queue_q[0]];
      image_height_n = meta_height[queue_q[0]];
      for (int i = 0; i < BUFFER_COUNT - 1; i++) queue_n[i] = queue_q[i + 1];
      count_n = count_q - CW'(1);
    end

    if (commit_ok) begin
      for (int b = 0; b < BUFFER_COUNT; b++) begin
        if (BW'(b) == write_buf_q) state_n[b] = READY;
      end
      if (LATEST_MODE != 0) begin
        // Every frame still waiting after the pop is superseded by this one.
        for (int b = 0; b < BUFFER_COUNT; b++) begin
          if ((state_q[b] == READY) && !(acquire_ok && (BW'(b) == queue_q[0]))) begin
            state_n[b]   = FREE;
            drop_mask[b] = 1'b1;
            drop_total   = drop_total + 1;
          end
        end
        queue_n[0] = write_buf_q;
        count_n    = CW'(1);
        drop_sum   = {1'b0, dropped_q} + 17'(drop_total);
        dropped_n  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end else begin
        for (int i = 0; i < BUFFER_COUNT; i++) begin
          if (i == int'(count_n)) queue_n[i] = write_buf_q;
        end
        count_n = count_n + CW'(1);
      end
      // Prefer a buffer that was free at the start of the cycle; in LATEST mode
      // a frame dropped by this very commit is the fallback, so the writer never
      // stalls there.
      if (|free_mask) begin
        claim     = 1'b1;
        claim_buf = lowest_set(free_mask);
      end else if (|drop_mask) begin
        claim     = 1'b1;
        claim_buf = lowest_set(drop_mask);
      end else begin
        write_owned_n = 1'b0;
      end
    end else if (!write_owned_q && (|start_free)) begin
      // Stalled writer picks up a buffer one cycle after it becomes free.
      claim     = 1'b1;
      claim_buf = lowest_set(start_free);
    end

    if (claim) begin
      write_buf_n   = claim_buf;
      write_owned_n = 1'b1;
      for (int b = 0; b < BUFFER_COUNT; b++) begin
        if (BW'(b) == claim_buf) state_n[b] = WRITING;
      end
    end
  end

  // Outputs derived from registered state.
  always_comb begin
    O_write_ready     = write_owned_q;
    O_frame_valid     = read_owned_q;
    O_frame_available = (count_q != '0);
    O_image_width     = image_width_q;
    O_image_height    = image_height_q;
    O_buffer_updated  = updated_q;
    O_dropped_count   = dropped_q;
    O_data_flat       = data_q;
    O_data_valid      = valid_q;
  end

  // Metadata is captured into the write frame on commit.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int b = 0; b < BUFFER_COUNT; b++) begin
        meta_width[b]  <= '0;
        meta_height[b] <= '0;
      end
    end else if (commit_ok) begin
      meta_width[write_buf_q]  <= I_image_width;
      meta_height[write_buf_q] <= I_image_height;
    end
  end

  // Frame storage keeps its contents across reset. Addresses past the end of a
  // block are dropped rather than aliased into another frame.
  always_ff @(posedge I_clk) begin
    if (write_owned_q && I_write_enable && (int'(I_write_address) < DEPTH)) begin
      mem[write_buf_q][I_write_address] <= I_data_flat;
    end
  end

  // Split the read address into a word address and a sub-word lane; lane 0 is
  // the least significant B bits of the stored word.
  always_comb begin
    rd_word_addr = AW_A'(I_read_address >> SUB_W);
    rd_sub       = int'(I_read_address) % RATIO;
    rd_word      = '0;
    rd_data      = '0;
    if (int'(rd_word_addr) < DEPTH) rd_word = mem[read_buf_q][rd_word_addr];
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      rd_data[c * DATA_WIDTH_B +: DATA_WIDTH_B] =
        rd_word[c * DATA_WIDTH_A + rd_sub * DATA_WIDTH_B +: DATA_WIDTH_B];
    end
  end

  // Registered read port; data holds its last value when no read is served.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= I_read_enable && read_owned_q;
      if (I_read_enable && read_owned_q) data_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_matrix_frame_ring.sv
// tb_matrix_frame_ring
// -----------------------------------------------------------------------------
// Directed bench for matrix_frame_ring. Three instances share one set of
// stimulus: FIFO with three buffers, FIFO with two buffers and LATEST with
// three buffers. Each scenario resets all of them and then checks the instance
// it is about. Inputs change 1 time unit after the rising edge, and outputs
// are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_matrix_frame_ring;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [9:0]    waddr = '0;
  logic [383:0]  wdata = '0;
  logic [10:0]   iw = '0;
  logic [10:0]   ih = '0;
  logic          commit = 1'b0;
  logic          acquire = 1'b0;
  logic          re = 1'b0;
  logic [11:0]   raddr = '0;

  logic          f3_write_ready, f3_data_valid, f3_frame_available, f3_frame_valid, f3_buffer_updated;
  logic [95:0]   f3_data_flat;
  logic [10:0]   f3_image_width, f3_image_height;
  logic [15:0]   f3_dropped_count;

  logic          f2_write_ready, f2_data_valid, f2_frame_available, f2_frame_valid, f2_buffer_updated;
  logic [95:0]   f2_data_flat;
  logic [10:0]   f2_image_width, f2_image_height;
  logic [15:0]   f2_dropped_count;

  logic          l3_write_ready, l3_data_valid, l3_frame_available, l3_frame_valid, l3_buffer_updated;
  logic [95:0]   l3_data_flat;
  logic [10:0]   l3_image_width, l3_image_height;
  logic [15:0]   l3_dropped_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_frame_ring #(.BUFFER_COUNT(3), .LATEST_MODE(0)) dut_fifo3 (
    .I_clk(clk), .I_rst_n(rst_n), .I_write_enable(we), .I_write_address(waddr),
    .I_data_flat(wdata), .I_image_width(iw), .I_image_height(ih), .I_commit(commit),
    .O_write_ready(f3_write_ready), .I_acquire(acquire), .I_read_enable(re),
    .I_read_address(raddr), .O_data_flat(f3_data_flat), .O_data_valid(f3_data_valid),
    .O_frame_available(f3_frame_available), .O_frame_valid(f3_frame_valid),
    .O_image_width(f3_image_width), .O_image_height(f3_image_height),
    .O_buffer_updated(f3_buffer_updated), .O_dropped_count(f3_dropped_count)
  );

  matrix_frame_ring #(.BUFFER_COUNT(2), .LATEST_MODE(0)) dut_fifo2 (
    .I_clk(clk), .I_rst_n(rst_n), .I_write_enable(we), .I_write_address(waddr),
    .I_data_flat(wdata), .I_image_width(iw), .I_image_height(ih), .I_commit(commit),
    .O_write_ready(f2_write_ready), .I_acquire(acquire), .I_read_enable(re),
    .I_read_address(raddr), .O_data_flat(f2_data_flat), .O_data_valid(f2_data_valid),
    .O_frame_available(f2_frame_available), .O_frame_valid(f2_frame_valid),
    .O_image_width(f2_image_width), .O_image_height(f2_image_height),
    .O_buffer_updated(f2_buffer_updated), .O_dropped_count(f2_dropped_count)
  );

  matrix_frame_ring #(.BUFFER_COUNT(3), .LATEST_MODE(1)) dut_latest3 (
    .I_clk(clk), .I_rst_n(rst_n), .I_write_enable(we), .I_write_address(waddr),
    .I_data_flat(wdata), .I_image_width(iw), .I_image_height(ih), .I_commit(commit),
    .O_write_ready(l3_write_ready), .I_acquire(acquire), .I_read_enable(re),
    .I_read_address(raddr), .O_data_flat(l3_data_flat), .O_data_valid(l3_data_valid),
    .O_frame_available(l3_frame_available), .O_frame_valid(l3_frame_valid),
    .O_image_width(l3_image_width), .O_image_height(l3_image_height),
    .O_buffer_updated(l3_buffer_updated), .O_dropped_count(l3_dropped_count)
  );

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; iw = '0; ih = '0;
    commit = 1'b0; acquire = 1'b0; re = 1'b0; raddr = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Word n of channel c holds c*256 + n + base.
  task automatic write_ramp(input int words, input int base);
    for (int n = 0; n < words; n++) begin
      we = 1'b1;
      waddr = 10'(n);
      for (int c = 0; c < 12; c++) wdata[c*32 +: 32] = 32'(c * 256 + n + base);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic commit_frame(input int w, input int h);
    iw = 11'(w);
    ih = 11'(h);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic acquire_pulse();
    acquire = 1'b1;
    tick();
    acquire = 1'b0;
  endtask

  task automatic read_at(input int a);
    re = 1'b1;
    raddr = 12'(a);
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (f3_write_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_write_ready got=%0b want=1", f3_write_ready);
    end
    checks++;
    if ({f3_frame_valid, f3_frame_available, f3_buffer_updated, f3_data_valid} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=0000",
               {f3_frame_valid, f3_frame_available, f3_buffer_updated, f3_data_valid});
    end
    checks++;
    if (f3_dropped_count !== 16'd0 || f3_image_width !== 11'd0 || f3_image_height !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_counters dropped=%0d w=%0d h=%0d want all 0",
               f3_dropped_count, f3_image_width, f3_image_height);
    end
    checks++;
    if (f3_data_flat !== 96'd0) begin
      failures++; $display("[TB] FAIL reset_data got=%0h want=0", f3_data_flat);
    end
  endtask

  task automatic test_fifo_basic();
    int tbl [8][3] = '{'{0, 0, 8'h00}, '{1, 0, 8'h00}, '{2, 0, 8'h00}, '{3, 0, 8'h00},
                       '{4, 0, 8'h01}, '{1, 5, 8'h05}, '{29, 11, 8'h0B}, '{28, 3, 8'h07}};
    logic [7:0] held;
    do_reset();
    write_ramp(8, 0);
    commit_frame(16, 8);
    checks++;
    if (f3_frame_available !== 1'b1 || f3_write_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_after_commit avail=%0b ready=%0b want 1 1",
               f3_frame_available, f3_write_ready);
    end
    acquire_pulse();
    checks++;
    if (f3_buffer_updated !== 1'b1 || f3_frame_valid !== 1'b1 || f3_frame_available !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_acquire upd=%0b valid=%0b avail=%0b want 1 1 0",
               f3_buffer_updated, f3_frame_valid, f3_frame_available);
    end
    checks++;
    if (f3_image_width !== 11'd16 || f3_image_height !== 11'd8) begin
      failures++;
      $display("[TB] FAIL basic_metadata got=%0dx%0d want=16x8", f3_image_width, f3_image_height);
    end
    tick();
    checks++;
    if (f3_buffer_updated !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_pulse_width got=%0b want=0", f3_buffer_updated);
    end
    re = 1'b1;
    raddr = '0;
    checks++;
    if (f3_data_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_valid_latency got=%0b want=0", f3_data_valid);
    end
    for (int i = 0; i < 8; i++) begin
      read_at(tbl[i][0]);
      checks++;
      if (f3_data_valid !== 1'b1 || f3_data_flat[tbl[i][1]*8 +: 8] !== 8'(tbl[i][2])) begin
        failures++;
        $display("[TB] FAIL basic_read addr=%0d ch=%0d valid=%0b got=%0h want=%0h",
                 tbl[i][0], tbl[i][1], f3_data_valid, f3_data_flat[tbl[i][1]*8 +: 8], tbl[i][2]);
      end
    end
    held = f3_data_flat[3*8 +: 8];
    raddr = 12'd4;
    tick();
    checks++;
    if (f3_data_valid !== 1'b0 || f3_data_flat[3*8 +: 8] !== 8'h07) begin
      failures++;
      $display("[TB] FAIL basic_hold valid=%0b got=%0h want=0 07 (held %0h)",
               f3_data_valid, f3_data_flat[3*8 +: 8], held);
    end
  endtask

  task automatic test_fifo_stall();
    int waited;
    do_reset();
    write_ramp(4, 0);
    commit_frame(16, 1);
    checks++;
    if (f2_write_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_first_commit_ready got=%0b want=1", f2_write_ready);
    end
    write_ramp(4, 'h40);
    commit_frame(16, 2);
    checks++;
    if (f2_write_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_ready_low got=%0b want=0", f2_write_ready);
    end
    we = 1'b1;
    waddr = '0;
    wdata = '1;
    tick();
    we = 1'b0;
    commit_frame(16, 7);
    acquire_pulse();
    checks++;
    if (f2_image_height !== 11'd1 || f2_write_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_first_frame h=%0d ready=%0b want 1 0", f2_image_height, f2_write_ready);
    end
    acquire_pulse();
    checks++;
    if (f2_image_height !== 11'd2 || f2_frame_available !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_second_frame h=%0d avail=%0b want 2 0", f2_image_height, f2_frame_available);
    end
    waited = 0;
    while (f2_write_ready !== 1'b1 && waited < 2) begin
      tick();
      waited++;
    end
    checks++;
    if (f2_write_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_release got=%0b want=1 within 2 cycles", f2_write_ready);
    end
    read_at(0);
    checks++;
    if (f2_data_valid !== 1'b1 || f2_data_flat[7:0] !== 8'h40) begin
      failures++;
      $display("[TB] FAIL stall_write_ignored valid=%0b got=%0h want=40", f2_data_valid, f2_data_flat[7:0]);
    end
    read_at(4);
    checks++;
    if (f2_data_flat[7:0] !== 8'h41) begin
      failures++; $display("[TB] FAIL stall_frame_data got=%0h want=41", f2_data_flat[7:0]);
    end
  endtask

  task automatic test_latest_drop();
    do_reset();
    commit_frame(16, 1);
    commit_frame(16, 2);
    commit_frame(16, 3);
    checks++;
    if (l3_dropped_count !== 16'd2 || l3_write_ready !== 1'b1 || l3_frame_available !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latest_drop dropped=%0d ready=%0b avail=%0b want 2 1 1",
               l3_dropped_count, l3_write_ready, l3_frame_available);
    end
    acquire_pulse();
    checks++;
    if (l3_image_height !== 11'd3 || l3_buffer_updated !== 1'b1 || l3_frame_available !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latest_newest h=%0d upd=%0b avail=%0b want 3 1 0",
               l3_image_height, l3_buffer_updated, l3_frame_available);
    end
    commit_frame(16, 4);
    commit_frame(16, 5);
    checks++;
    if (l3_dropped_count !== 16'd3 || l3_write_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latest_full_ring dropped=%0d ready=%0b want 3 1", l3_dropped_count, l3_write_ready);
    end
    acquire_pulse();
    checks++;
    if (l3_image_height !== 11'd5) begin
      failures++; $display("[TB] FAIL latest_second_acquire h=%0d want=5", l3_image_height);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    commit_frame(16, 1);
    iw = 11'd16;
    ih = 11'd2;
    commit = 1'b1;
    acquire = 1'b1;
    tick();
    commit = 1'b0;
    acquire = 1'b0;
    checks++;
    if (f3_image_height !== 11'd1 || f3_buffer_updated !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_older_frame h=%0d upd=%0b want 1 1", f3_image_height, f3_buffer_updated);
    end
    checks++;
    if (f3_frame_available !== 1'b1 || f3_write_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_new_ready avail=%0b ready=%0b want 1 1", f3_frame_available, f3_write_ready);
    end
    acquire_pulse();
    checks++;
    if (f3_image_height !== 11'd2 || f3_frame_available !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_next_frame h=%0d avail=%0b want 2 0", f3_image_height, f3_frame_available);
    end
  endtask

  task automatic test_empty_acquire();
    do_reset();
    re = 1'b1;
    acquire = 1'b1;
    tick();
    acquire = 1'b0;
    re = 1'b0;
    checks++;
    if ({f3_buffer_updated, f3_frame_valid, f3_data_valid} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL empty_fresh got=%b want=000", {f3_buffer_updated, f3_frame_valid, f3_data_valid});
    end
    commit_frame(16, 6);
    acquire_pulse();
    tick();
    acquire_pulse();
    checks++;
    if (f3_buffer_updated !== 1'b0 || f3_frame_valid !== 1'b1 || f3_image_height !== 11'd6) begin
      failures++;
      $display("[TB] FAIL empty_keep upd=%0b valid=%0b h=%0d want 0 1 6",
               f3_buffer_updated, f3_frame_valid, f3_image_height);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_ramp(4, 0);
    commit_frame(16, 8);
    acquire_pulse();
    we = 1'b1;
    waddr = 10'd1;
    wdata = '1;
    re = 1'b1;
    raddr = 12'd4;
    tick();
    checks++;
    if (f3_data_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_read_active got=%0b want=1", f3_data_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({f3_frame_valid, f3_frame_available, f3_data_valid, f3_buffer_updated} !== 4'b0000 ||
        f3_data_flat !== 96'd0 || f3_image_width !== 11'd0 || f3_image_height !== 11'd0 ||
        f3_dropped_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_async flags=%b data=%0h w=%0d h=%0d want all 0",
               {f3_frame_valid, f3_frame_available, f3_data_valid, f3_buffer_updated},
               f3_data_flat, f3_image_width, f3_image_height);
    end
    we = 1'b0;
    re = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (f3_write_ready !== 1'b1 || f3_frame_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_release ready=%0b valid=%0b want 1 0", f3_write_ready, f3_frame_valid);
    end
    write_ramp(2, 'h20);
    commit_frame(32, 4);
    acquire_pulse();
    checks++;
    if (f3_image_width !== 11'd32 || f3_image_height !== 11'd4) begin
      failures++;
      $display("[TB] FAIL mid_reset_meta got=%0dx%0d want=32x4", f3_image_width, f3_image_height);
    end
    read_at(0);
    checks++;
    if (f3_data_flat[7:0] !== 8'h20) begin
      failures++; $display("[TB] FAIL mid_reset_word0 got=%0h want=20", f3_data_flat[7:0]);
    end
    read_at(4);
    checks++;
    if (f3_data_flat[7:0] !== 8'h21) begin
      failures++; $display("[TB] FAIL mid_reset_word1 got=%0h want=21", f3_data_flat[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_fifo_stall();
    test_latest_drop();
    test_back_to_back();
    test_empty_acquire();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
